// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: builds RV32I instruction words from field requests and
// streams them one per cycle into instruction memory under a load FSM.
module instr_encoder_loader #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0,
   parameter int DEPTH     = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_op,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_funct7b5,
   input  logic [31:0]       in_imm,
   input  logic              in_last,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words
);
   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
   localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);
   state_t state;
   logic out_valid, shift, legal, accept, wr, s11, s12, s20;
   logic [31:0] enc;
   logic [ADDR_W:0] cnt;
   assign s11 = &in_imm[31:11] | ~|in_imm[31:11];
   assign s12 = &in_imm[31:12] | ~|in_imm[31:12];
   assign s20 = &in_imm[31:20] | ~|in_imm[31:20];
   assign shift = in_fmt == 3'd0 && in_op == 7'h13 && in_funct3[1:0] == 2'b01;
   always_comb begin
      legal = 1'b0;
      enc = '0;
      case (in_fmt)
         3'd0: begin
            legal = shift ? ~|in_imm[31:5] : s11;
            enc = shift ? {1'b0, in_funct7b5, 5'b0, in_imm[4:0], in_rs1, in_funct3, in_rd, in_op}
                        : {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
         end
         3'd1: begin
            legal = s11;
            enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
         end
         3'd2: begin
            legal = s12 & ~in_imm[0];
            enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_op};
         end
         3'd3: begin
            legal = s20 & ~in_imm[0];
            enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
         end
         3'd4: begin
            legal = ~|in_imm[11:0];
            enc = {in_imm[31:12], in_rd, in_op};
         end
         3'd5: begin
            legal = 1'b1;
            enc = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_op};
         end
         default: begin
            legal = 1'b0;
            enc = '0;
         end
      endcase
   end
   assign in_ready = state == LOAD && (!out_valid || mem_ready);
   assign accept = in_valid && in_ready;
   assign wr = out_valid && mem_ready;
   assign mem_we = out_valid;
   assign busy = state == LOAD || state == DRAIN;
   assign done = state == DONE;
   // the address advances on write completion, so a word loaded on that same edge lands on the next slot
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         out_valid <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         words <= '0;
         err <= 1'b0;
         cnt <= '0;
      end else begin
         if (wr) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            words <= words + (ADDR_W+1)'(1);
         end
         out_valid <= accept ? legal : out_valid && !mem_ready;
         if (accept && legal) mem_wdata <= enc;
         if (accept) begin
            cnt <= cnt + (ADDR_W+1)'(1);
            err <= err | ~legal;
         end
         case (state)
            IDLE, DONE: if (start) begin
               state <= LOAD;
               words <= '0;
               err <= 1'b0;
               cnt <= '0;
               mem_addr <= ADDR_W'(BASE_ADDR);
            end
            LOAD: if (accept && (in_last || cnt == LAST_CNT)) state <= DRAIN;
            DRAIN: if (!out_valid || mem_ready) state <= DONE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
